// File: rtl/mst_data_gen_mc.sv
// Multi-channel streaming pattern generator (inc / dec / LFSR / walking-one, 32- or 16-bit bus).
// Optional error injection on ch_dat bit 0 is compiled in with `define MST_DATA_GEN_ERR_INJ_EN.
module mst_data_gen_mc #(
  parameter int NUM_CH = 4,
  parameter int LEN_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bus16,
  input  logic [2*NUM_CH-1:0]   ch_mode,
  input  logic [NUM_CH-1:0]     ch_req,
  input  logic [NUM_CH-1:0]     ch_clr,
  input  logic [LEN_W-1:0]      pkt_len_m1,
  output logic [32*NUM_CH-1:0]  ch_dat,
  output logic [NUM_CH-1:0]     ch_last
`ifdef MST_DATA_GEN_ERR_INJ_EN
  ,
  input  logic [NUM_CH-1:0]     ch_err_inj
`endif
);

  typedef enum logic [1:0] {
    MODE_INC  = 2'b00,
    MODE_DEC  = 2'b01,
    MODE_LFSR = 2'b10,
    MODE_WALK = 2'b11
  } mode_e;

  localparam logic [31:0] DAT_RST = 32'hFFFF_FFFF;

  // Next pattern word, computed on the active width only; inactive upper bits come out zero.
  function automatic logic [31:0] next_word(input logic [31:0] cur, input mode_e mode,
                                            input logic b16);
    logic [31:0] mask;
    logic [31:0] c;
    logic [31:0] n;
    mask = b16 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    c    = cur & mask;
    n    = 32'd0;
    case (mode)
      MODE_INC:  n = c + 32'd1;
      MODE_DEC:  n = c - 32'd1;
      MODE_LFSR: begin
        if (c == 32'd0)
          n = mask;
        else if (b16)
          n = {16'h0000, c[14:0], c[15] ^ c[13] ^ c[12] ^ c[10]};
        else
          n = {c[30:0], c[31] ^ c[21] ^ c[1] ^ c[0]};
      end
      MODE_WALK: begin
        if (c != 32'd0 && (c & (c - 32'd1)) == 32'd0)
          n = b16 ? {16'h0000, c[14:0], c[15]} : {c[30:0], c[31]};
        else
          n = 32'd1;
      end
      default:   n = 32'd1;
    endcase
    return n & mask;
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [31:0]      state;
    logic             last;
    logic [LEN_W-1:0] cnt;
    logic [31:0]      nxt;

    assign nxt = next_word(state, mode_e'(ch_mode[2*i +: 2]), bus16);

    // NOTE: state registers use non-blocking assignments so every channel samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= DAT_RST;
        last  <= 1'b0;
        cnt   <= '0;
      end else if (ch_clr[i]) begin
        state <= DAT_RST;
        last  <= 1'b0;
        cnt   <= '0;
      end else if (ch_req[i]) begin
        state <= nxt;
        if (cnt == pkt_len_m1) begin
          cnt  <= '0;
          last <= 1'b1;
        end else begin
          cnt  <= cnt + 1'b1;
          last <= 1'b0;
        end
      end
    end

    assign ch_last[i] = last;

`ifdef MST_DATA_GEN_ERR_INJ_EN
    logic        pend;
    logic [31:0] dat_q;

    // The corruption lives only in the output copy so the pattern state stays clean.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pend  <= 1'b0;
        dat_q <= DAT_RST;
      end else if (ch_clr[i]) begin
        pend  <= 1'b0;
        dat_q <= DAT_RST;
      end else begin
        if (ch_req[i])
          dat_q <= nxt ^ {31'd0, pend};
        pend <= (ch_req[i] ? 1'b0 : pend) | ch_err_inj[i];
      end
    end

    assign ch_dat[32*i +: 32] = dat_q;
`else
    assign ch_dat[32*i +: 32] = state;
`endif
  end

endmodule

// File: tb/tb_mst_data_gen_mc.sv
// Directed self-checking bench for mst_data_gen_mc; error-injection test runs only when
// MST_DATA_GEN_ERR_INJ_EN is defined.
module tb_mst_data_gen_mc;
  localparam int NUM_CH = 4;
  localparam int LEN_W  = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 bus16;
  logic [2*NUM_CH-1:0]  ch_mode;
  logic [NUM_CH-1:0]    ch_req;
  logic [NUM_CH-1:0]    ch_clr;
  logic [LEN_W-1:0]     pkt_len_m1;
  logic [32*NUM_CH-1:0] ch_dat;
  logic [NUM_CH-1:0]    ch_last;
`ifdef MST_DATA_GEN_ERR_INJ_EN
  logic [NUM_CH-1:0]    ch_err_inj;
`endif

  int checks = 0;
  int errors = 0;

  mst_data_gen_mc #(.NUM_CH(NUM_CH), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus16      (bus16),
    .ch_mode    (ch_mode),
    .ch_req     (ch_req),
    .ch_clr     (ch_clr),
    .pkt_len_m1 (pkt_len_m1),
    .ch_dat     (ch_dat),
    .ch_last    (ch_last)
`ifdef MST_DATA_GEN_ERR_INJ_EN
    ,
    .ch_err_inj (ch_err_inj)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] dat(input int c);
    return ch_dat[32*c +: 32];
  endfunction

  task automatic set_mode(input int c, input logic [1:0] m);
    ch_mode[2*c +: 2] = m;
  endtask

  task automatic clr_ch(input int c);
    ch_clr[c] = 1'b1;
    tick();
    ch_clr[c] = 1'b0;
  endtask

  task automatic req_ch(input int c);
    ch_req[c] = 1'b1;
    tick();
    ch_req[c] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    for (int c = 0; c < NUM_CH; c++) begin
      checks++;
      if (dat(c) !== 32'hFFFF_FFFF || ch_last[c] !== 1'b0) begin
        errors++;
        $display("FAIL reset ch%0d dat=%h last=%b expected ffffffff/0", c, dat(c), ch_last[c]);
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_inc();
    logic [31:0] exp [3];
    exp = '{32'h0, 32'h1, 32'h2};
    set_mode(0, 2'b00);
    for (int k = 0; k < 3; k++) begin
      req_ch(0);
      checks++;
      if (dat(0) !== exp[k]) begin
        errors++;
        $display("FAIL inc32 beat%0d got=%h expected=%h", k, dat(0), exp[k]);
      end
    end
    for (int c = 1; c < NUM_CH; c++) begin
      checks++;
      if (dat(c) !== 32'hFFFF_FFFF) begin
        errors++;
        $display("FAIL idle ch%0d got=%h expected=ffffffff", c, dat(c));
      end
    end
  endtask

  task automatic test_bus16_wrap();
    int lasts;
    lasts = 0;
    bus16 = 1'b1;
    pkt_len_m1 = 16'd15;
    set_mode(0, 2'b00);
    clr_ch(0);
    ch_req[0] = 1'b1;
    for (int k = 0; k < 65536; k++) begin
      tick();
      if (ch_last[0] === 1'b1) lasts++;
    end
    ch_req[0] = 1'b0;
    checks++;
    if (dat(0) !== 32'h0000_FFFF || ch_last[0] !== 1'b1) begin
      errors++;
      $display("FAIL bus16_preload got=%h last=%b expected 0000ffff/1", dat(0), ch_last[0]);
    end
    checks++;
    if (lasts !== 4096) begin
      errors++;
      $display("FAIL bus16_last_count got=%0d expected=4096", lasts);
    end
    req_ch(0);
    checks++;
    if (dat(0) !== 32'h0000_0000 || ch_last[0] !== 1'b0) begin
      errors++;
      $display("FAIL bus16_wrap got=%h last=%b expected 00000000/0", dat(0), ch_last[0]);
    end
    bus16 = 1'b0;
  endtask

  task automatic test_pkt_last();
    logic exp;
    pkt_len_m1 = 16'd3;
    set_mode(1, 2'b00);
    clr_ch(1);
    ch_req[1] = 1'b1;
    for (int b = 1; b <= 8; b++) begin
      tick();
      exp = (b % 4 == 0);
      checks++;
      if (ch_last[1] !== exp || dat(1) !== 32'(b - 1)) begin
        errors++;
        $display("FAIL pkt4 beat%0d last=%b dat=%h expected %b/%h", b, ch_last[1], dat(1), exp, b - 1);
      end
    end
    ch_req[1] = 1'b0;
    tick();
    checks++;
    if (ch_last[1] !== 1'b1 || dat(1) !== 32'd7) begin
      errors++;
      $display("FAIL pkt_hold last=%b dat=%h expected 1/00000007", ch_last[1], dat(1));
    end
    pkt_len_m1 = 16'd0;
    for (int b = 0; b < 3; b++) begin
      req_ch(1);
      checks++;
      if (ch_last[1] !== 1'b1) begin
        errors++;
        $display("FAIL pkt_len1 beat%0d last=%b expected 1", b, ch_last[1]);
      end
    end
    pkt_len_m1 = 16'd7;
    clr_ch(1);
    req_ch(1);
    req_ch(1);
    pkt_len_m1 = 16'd3;
    req_ch(1);
    checks++;
    if (ch_last[1] !== 1'b0) begin
      errors++;
      $display("FAIL pkt_shrink beat3 last=%b expected 0", ch_last[1]);
    end
    req_ch(1);
    checks++;
    if (ch_last[1] !== 1'b1) begin
      errors++;
      $display("FAIL pkt_shrink beat4 last=%b expected 1", ch_last[1]);
    end
  endtask

  task automatic test_walk();
    logic [31:0] exp [3];
    exp = '{32'h1, 32'h2, 32'h4};
    set_mode(0, 2'b11);
    clr_ch(0);
    for (int k = 0; k < 3; k++) begin
      req_ch(0);
      checks++;
      if (dat(0) !== exp[k]) begin
        errors++;
        $display("FAIL walk32 beat%0d got=%h expected=%h", k, dat(0), exp[k]);
      end
    end
    ch_req[0] = 1'b1;
    repeat (29) tick();
    checks++;
    if (dat(0) !== 32'h8000_0000) begin
      errors++;
      $display("FAIL walk32_msb got=%h expected=80000000", dat(0));
    end
    repeat (3) tick();
    ch_req[0] = 1'b0;
    checks++;
    if (dat(0) !== 32'h4) begin
      errors++;
      $display("FAIL walk32_wrap got=%h expected=00000004", dat(0));
    end
    bus16 = 1'b1;
    clr_ch(0);
    ch_req[0] = 1'b1;
    repeat (16) tick();
    checks++;
    if (dat(0) !== 32'h0000_8000) begin
      errors++;
      $display("FAIL walk16_msb got=%h expected=00008000", dat(0));
    end
    tick();
    ch_req[0] = 1'b0;
    checks++;
    if (dat(0) !== 32'h1) begin
      errors++;
      $display("FAIL walk16_wrap got=%h expected=00000001", dat(0));
    end
    bus16 = 1'b0;
  endtask

  task automatic test_clr_priority();
    set_mode(2, 2'b10);
    req_ch(2);
    req_ch(2);
    ch_clr[2] = 1'b1;
    ch_req[2] = 1'b1;
    tick();
    ch_clr[2] = 1'b0;
    ch_req[2] = 1'b0;
    checks++;
    if (dat(2) !== 32'hFFFF_FFFF || ch_last[2] !== 1'b0) begin
      errors++;
      $display("FAIL clr_req got=%h last=%b expected ffffffff/0", dat(2), ch_last[2]);
    end
    req_ch(2);
    checks++;
    if (dat(2) !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL lfsr32_first got=%h expected=fffffffe", dat(2));
    end
  endtask

  task automatic test_modes();
    set_mode(3, 2'b01);
    clr_ch(3);
    req_ch(3);
    req_ch(3);
    checks++;
    if (dat(3) !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL dec32 got=%h expected=fffffffd", dat(3));
    end
    set_mode(3, 2'b00);
    clr_ch(3);
    req_ch(3);
    set_mode(3, 2'b01);
    req_ch(3);
    checks++;
    if (dat(3) !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL dec_zero got=%h expected=ffffffff", dat(3));
    end
    set_mode(3, 2'b00);
    req_ch(3);
    set_mode(3, 2'b10);
    req_ch(3);
    checks++;
    if (dat(3) !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL lfsr_escape got=%h expected=ffffffff", dat(3));
    end
    bus16 = 1'b1;
    req_ch(3);
    checks++;
    if (dat(3) !== 32'h0000_FFFE) begin
      errors++;
      $display("FAIL lfsr16_a got=%h expected=0000fffe", dat(3));
    end
    req_ch(3);
    checks++;
    if (dat(3) !== 32'h0000_FFFC) begin
      errors++;
      $display("FAIL lfsr16_b got=%h expected=0000fffc", dat(3));
    end
    bus16 = 1'b0;
  endtask

  task automatic test_async_reset();
    set_mode(0, 2'b00);
    pkt_len_m1 = 16'd0;
    clr_ch(0);
    req_ch(0);
    req_ch(0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dat(0) !== 32'hFFFF_FFFF || ch_last[0] !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got=%h last=%b expected ffffffff/0", dat(0), ch_last[0]);
    end
    #3 rst_n = 1'b1;
    tick();
  endtask

`ifdef MST_DATA_GEN_ERR_INJ_EN
  task automatic test_err_inj();
    set_mode(3, 2'b00);
    clr_ch(3);
    req_ch(3);
    ch_err_inj[3] = 1'b1;
    tick();
    ch_err_inj[3] = 1'b0;
    req_ch(3);
    checks++;
    if (dat(3) !== 32'h0000_0000) begin
      errors++;
      $display("FAIL err_inj_word got=%h expected=00000000", dat(3));
    end
    req_ch(3);
    checks++;
    if (dat(3) !== 32'h0000_0002) begin
      errors++;
      $display("FAIL err_inj_after got=%h expected=00000002", dat(3));
    end
    ch_err_inj[3] = 1'b1;
    tick();
    ch_err_inj[3] = 1'b0;
    clr_ch(3);
    req_ch(3);
    checks++;
    if (dat(3) !== 32'h0000_0000) begin
      errors++;
      $display("FAIL err_inj_clr got=%h expected=00000000", dat(3));
    end
  endtask
`endif

  initial begin
    rst_n      = 1'b0;
    bus16      = 1'b0;
    ch_mode    = '0;
    ch_req     = '0;
    ch_clr     = '0;
    pkt_len_m1 = 16'd15;
`ifdef MST_DATA_GEN_ERR_INJ_EN
    ch_err_inj = '0;
`endif
    test_reset();
    test_inc();
    test_bus16_wrap();
    test_pkt_last();
    test_walk();
    test_clr_priority();
    test_modes();
    test_async_reset();
`ifdef MST_DATA_GEN_ERR_INJ_EN
    test_err_inj();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
